// File: rtl/mcac_channel_sequencer_if.sv
// mcac_channel_sequencer_if
// Bundles the timer frame-sync strobe, the codec-core start/done handshake,
// the overrun clear and the sequencer status outputs.
//   master : sequencer side  -- drives core_start, ch_idx, busy, frame_done,
//                               overrun, ovr_cnt, wdog_err
//   slave  : environment side -- drives fs_pulse, core_done, ovr_clr
interface mcac_channel_sequencer_if #(
  parameter int CH_W = 5
);
  logic            fs_pulse;
  logic            core_done;
  logic            ovr_clr;
  logic            core_start;
  logic [CH_W-1:0] ch_idx;
  logic            busy;
  logic            frame_done;
  logic            overrun;
  logic [7:0]      ovr_cnt;
  logic            wdog_err;

  modport master (
    input  fs_pulse, core_done, ovr_clr,
    output core_start, ch_idx, busy, frame_done, overrun, ovr_cnt, wdog_err
  );

  modport slave (
    output fs_pulse, core_done, ovr_clr,
    input  core_start, ch_idx, busy, frame_done, overrun, ovr_cnt, wdog_err
  );
endinterface

// File: rtl/mcac_channel_sequencer.sv
// mcac_channel_sequencer
// Walks the time-multiplexed codec core through channels 0..NUM_CH-1 once per
// frame-sync strobe, using a one-cycle core_start / core_done handshake.
// A frame-sync strobe that lands mid-frame is counted as an overrun; the
// running frame always completes.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   sq (master)         fs_pulse/core_done/ovr_clr in; core_start, ch_idx,
//                       busy, frame_done, overrun, ovr_cnt, wdog_err out
//   scan_in0..4, scan_enable, test_mode   DFT hooks, unused functionally
//   scan_out0..4        DFT hooks, driven 0 until scan insertion
//
// Build option: define SEQ_WATCHDOG_EN to add a WAIT-state watchdog that
// forces the channel to advance after WDOG_CYC cycles without core_done and
// raises sticky wdog_err. Without it wdog_err is tied low.
module mcac_channel_sequencer #(
  parameter int NUM_CH   = 32,
  parameter int CH_W     = 5,
  parameter int WDOG_CYC = 255
) (
  input  logic                          clk,
  input  logic                          reset,
  mcac_channel_sequencer_if.master      sq,
  input  logic                          scan_in0,
  input  logic                          scan_in1,
  input  logic                          scan_in2,
  input  logic                          scan_in3,
  input  logic                          scan_in4,
  input  logic                          scan_enable,
  input  logic                          test_mode,
  output logic                          scan_out0,
  output logic                          scan_out1,
  output logic                          scan_out2,
  output logic                          scan_out3,
  output logic                          scan_out4
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_e;

  state_e          state, state_nxt;
  logic [CH_W-1:0] ch_idx_q, ch_idx_nxt;
  logic            core_start_q, busy_q, frame_done_q;
  logic            overrun_q;
  logic [7:0]      ovr_cnt_q;
  logic            done_nxt;
  logic            ovr_hit;
  logic            last_ch;
  logic            wdog_hit;
  logic            adv;

  assign last_ch = (ch_idx_q == CH_W'(NUM_CH - 1));
  // A watchdog expiry advances the sequencer exactly like a real core_done.
  assign adv     = (state == S_WAIT) && (sq.core_done || wdog_hit);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt  = state;
    ch_idx_nxt = ch_idx_q;
    done_nxt   = 1'b0;
    ovr_hit    = 1'b0;
    unique case (state)
      S_IDLE: begin
        // core_done is meaningless here and is dropped.
        if (sq.fs_pulse) begin
          state_nxt  = S_ISSUE;
          ch_idx_nxt = '0;
        end
      end
      S_ISSUE: begin
        // core_done cannot belong to this channel yet; ignore it.
        state_nxt = S_WAIT;
        ovr_hit   = sq.fs_pulse;
      end
      S_WAIT: begin
        if (adv) begin
          if (!last_ch) begin
            state_nxt  = S_ISSUE;
            ch_idx_nxt = ch_idx_q + CH_W'(1);
            ovr_hit    = sq.fs_pulse;
          end else begin
            // Strobe coincident with the final done is the next frame's
            // start, not an overrun.
            done_nxt = 1'b1;
            if (sq.fs_pulse) begin
              state_nxt  = S_ISSUE;
              ch_idx_nxt = '0;
            end else begin
              state_nxt = S_IDLE;
            end
          end
        end else begin
          ovr_hit = sq.fs_pulse;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and registered outputs. Outputs are decoded from next-state so they
  // line up with the state register and have no input-to-output path.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      ch_idx_q     <= '0;
      core_start_q <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state        <= state_nxt;
      ch_idx_q     <= ch_idx_nxt;
      core_start_q <= (state_nxt == S_ISSUE);
      busy_q       <= (state_nxt != S_IDLE);
      frame_done_q <= done_nxt;
    end
  end

  // Overrun tracking: a new overrun beats a same-cycle clear, so the count
  // restarts at 1 rather than 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun_q <= 1'b0;
      ovr_cnt_q <= '0;
    end else if (ovr_hit) begin
      overrun_q <= 1'b1;
      if (sq.ovr_clr)
        ovr_cnt_q <= 8'd1;
      else if (ovr_cnt_q != 8'hFF)
        ovr_cnt_q <= ovr_cnt_q + 8'd1;
    end else if (sq.ovr_clr) begin
      overrun_q <= 1'b0;
      ovr_cnt_q <= '0;
    end
  end

`ifdef SEQ_WATCHDOG_EN
  // Counter holds 0 outside WAIT, so it is cleared on every WAIT entry and
  // reads k during the (k+1)-th WAIT cycle. Expiry fires on the WDOG_CYC-th.
  logic [7:0] wdog_cnt;
  logic       wdog_err_q;

  assign wdog_hit = (state == S_WAIT) && !sq.core_done &&
                    (wdog_cnt == 8'(WDOG_CYC - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wdog_cnt   <= '0;
      wdog_err_q <= 1'b0;
    end else begin
      if (state != S_WAIT)
        wdog_cnt <= '0;
      else if (wdog_cnt != 8'hFF)
        wdog_cnt <= wdog_cnt + 8'd1;

      if (wdog_hit)
        wdog_err_q <= 1'b1;
      else if (sq.ovr_clr)
        wdog_err_q <= 1'b0;
    end
  end

  assign sq.wdog_err = wdog_err_q;
`else
  logic [7:0] unused_wdog;

  assign wdog_hit    = 1'b0;
  assign unused_wdog = 8'(WDOG_CYC);
  assign sq.wdog_err = 1'b0;
`endif

  assign sq.core_start = core_start_q;
  assign sq.ch_idx     = ch_idx_q;
  assign sq.busy       = busy_q;
  assign sq.frame_done = frame_done_q;
  assign sq.overrun    = overrun_q;
  assign sq.ovr_cnt    = ovr_cnt_q;

  // DFT placeholders until scan stitching.
  logic unused_dft;
  assign unused_dft = ^{scan_in0, scan_in1, scan_in2, scan_in3, scan_in4,
                        scan_enable, test_mode};
  assign scan_out0 = 1'b0;
  assign scan_out1 = 1'b0;
  assign scan_out2 = 1'b0;
  assign scan_out3 = 1'b0;
  assign scan_out4 = 1'b0;

endmodule
